alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the ALU control decoder.
- Consumes the 4-bit alucontrol code plus two operands and a destination tag from the ID/EX boundary.
- Performs the ALU operation and presents a registered result to EX/MEM over a valid/ready handshake.
- Holds a 2-entry elastic buffer (output register + skid register), so back-pressure never creates a combinational ready path upstream.

Parameters:
XLEN, 32, operand/result width
TAGW, 5, destination register tag width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held entries (branch mispredict)
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_alucontrol  in  4  ALU operation code (shared package encoding)
in_a  in  XLEN  operand A
in_b  in  XLEN  operand B
in_tag  in  TAGW  destination tag, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  XLEN  ALU result
out_zero  out  1  out_result == 0
out_illegal  out  1  entry carried an unsupported alucontrol code
out_tag  out  TAGW  destination tag

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_result=0, out_zero=0, out_illegal=0, out_tag=0, skid empty, in_ready=1.
- Opcodes:
  - ALU_AND=4'b0000: a&b
  - ALU_OR=4'b0001: a|b
  - ALU_ADD=4'b0010: a+b, modulo 2^XLEN, carry discarded
  - ALU_SUB=4'b0110: a-b, modulo 2^XLEN
  - Any other code, including ALU_INVALID=4'b1111: result=0, out_illegal=1, out_zero=1.
- Transfer rules: input accepted iff in_valid && in_ready; output consumed iff out_valid && out_ready.
- Latency: an accepted entry appears on outputs the next cycle when the output register is free. Throughput is 1/cycle while out_ready=1.
- in_ready is a register: in_ready = skid empty. It does not depend combinationally on out_ready.
- States, encoded by {out_valid, skid_valid}:
  - EMPTY(00): accept -> FULL1.
  - FULL1(10):
    - accept & consume -> FULL1 (new entry loads output register)
    - accept & !consume -> FULL2 (new entry loads skid)
    - consume only -> EMPTY
  - FULL2(11), in_ready=0:
    - consume -> FULL1, skid moves to output register, in_ready=1 next cycle
  - 01 is illegal; covered by an assertion.
- Ordering: strict FIFO. The skid entry is always older than any later entry.
- The result is computed before registering. Both output and skid registers store computed result, zero, illegal and tag.
- out_* fields remain stable while out_valid && !out_ready.
- flush:
  - Next cycle out_valid=0, skid empty, in_ready=1.
  - An entry presented in the flush cycle is dropped even if in_ready=1.
  - flush overrides simultaneous consume.
- Reset asserted mid-stream: all entries discarded immediately; outputs take reset values asynchronously.
- Data outputs are don't-care when out_valid=0, but are held at last value (no X).

Decomposition:
- Shared package alu_pkg holds:
  - ALU op codes (AND/OR/ADD/SUB/INVALID) as a 4-bit enum typedef alu_op_t, replacing the current global defines.
  - ALUOP class codes.
  - typedef ex_entry_t {result, zero, illegal, tag}.
- One natural sub-module: alu_core, purely combinational (op, a, b -> result, zero, illegal), instantiated once on the input path.

Test Plan:
- Reset then ADD a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, illegal=0.
- SUB a=0x10, b=0x10, then SUB a=0, b=1 back-to-back -> results 0 (zero=1), then 0xFFFFFFFF (zero=0), one per cycle.
- out_ready=0, push AND 0xF0F0&0xFF00, then OR 0x1|0x2 -> in_ready drops to 0 after 2nd accept; third in_valid stalls. Raise out_ready -> 0xF000 then 0x3, in order, in_ready returns to 1.
- alucontrol=4'b1111, a=3, b=4 -> result=0, illegal=1, zero=1, tag passed through.
- FULL2 state with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and incoming entries never appear.
- ADD 0xFFFFFFFF+1 -> result 0, zero=1. Assert rst_n low while FULL2 -> out_valid=0 immediately, no stale output after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings and execute-stage entry type
// Contents: alu_op_t (4-bit alucontrol codes), aluop_class_t (decoder ALUOp
// classes), ex_entry_t (one held execute result), default widths.
package alu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int TAGW_DEF = 5;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_INVALID = 4'b1111
  } alu_op_t;

  // ALUOp class driven by the main decoder into the ALU control decoder.
  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } aluop_class_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic                zero;
    logic                illegal;
    logic [TAGW_DEF-1:0] tag;
  } ex_entry_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath
// Ports:
//   op_i      alucontrol code
//   a_i, b_i  operands
//   result_o  operation result (0 for unsupported codes)
//   zero_o    result_o == 0
//   illegal_o op_i is not a supported code
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      default: illegal_o = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with 2-entry elastic output buffer
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            kill all held entries and any entry presented this cycle
//   in_valid/ready   upstream handshake; in_ready is registered (skid empty)
//   in_alucontrol    ALU operation code
//   in_a, in_b       operands
//   in_tag           destination tag, passed through
//   out_valid/ready  downstream handshake
//   out_result       ALU result
//   out_zero         out_result == 0
//   out_illegal      entry carried an unsupported alucontrol code
//   out_tag          destination tag
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alucontrol,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_illegal,
  output logic [TAGW-1:0] out_tag
);

  // Same layout as ex_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [TAGW-1:0] tag;
  } entry_t;

  // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } state_t;

  state_t state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;

  logic [XLEN-1:0] core_result;
  logic            core_zero;
  logic            core_illegal;
  logic            accept;
  logic            consume;

  alu_core #(.XLEN(XLEN)) u_core (
    .op_i      (in_alucontrol),
    .a_i       (in_a),
    .b_i       (in_b),
    .result_o  (core_result),
    .zero_o    (core_zero),
    .illegal_o (core_illegal)
  );

  assign new_entry = '{result: core_result, zero: core_zero,
                       illegal: core_illegal, tag: in_tag};

  // in_ready comes straight from the state register, so out_ready never
  // reaches the upstream ready path.
  assign in_ready  = ~state_q[0];
  assign out_valid = state_q[1];

  // A flush kills the incoming entry and any consume, so registers keep
  // their last values while the state returns to EMPTY.
  assign accept  = in_valid & in_ready & ~flush;
  assign consume = out_valid & out_ready & ~flush;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = new_entry;
          state_d = ST_FULL1;
        end
      end
      ST_FULL1: begin
        if (accept && consume) begin
          out_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = ST_FULL2;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        // in_ready is low here, so the only move is skid -> output.
        if (consume) begin
          out_d   = skid_q;
          state_d = ST_FULL1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign out_result  = out_q.result;
  assign out_zero    = out_q.zero;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

  a_no_skid_without_output: assert property (
    @(posedge clk) disable iff (!rst_n) state_q != 2'b01
  );

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alucontrol;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic [4:0]  out_tag;

  int checks = 0;
  int errors = 0;

  // {valid, result, zero, illegal, tag}
  logic [39:0] obs;
  logic [39:0] exp_v;
  assign obs = {out_valid, out_result, out_zero, out_illegal, out_tag};

  alu_exec_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alucontrol (in_alucontrol),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_illegal   (out_illegal),
    .out_tag       (out_tag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    in_valid      = v;
    in_alucontrol = op;
    in_a          = a;
    in_b          = b;
    in_tag        = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    #12;
    exp_v = 40'h0;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_out got %h exp %h", obs, exp_v); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== exp_v || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset got %h rdy %b exp %h rdy 1", obs, in_ready, exp_v);
    end
  endtask

  task automatic test_add();
    drive(1'b1, 4'b0010, 32'd5, 32'd7, 5'd3);
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    exp_v = {1'b1, 32'd12, 1'b0, 1'b0, 5'd3};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL add_out got %h exp %h", obs, exp_v); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'b0110, 32'h10, 32'h10, 5'd1);
    step();
    drive(1'b1, 4'b0110, 32'h0, 32'h1, 5'd2);
    exp_v = {1'b1, 32'h0, 1'b1, 1'b0, 5'd1};
    checks++;
    if (obs !== exp_v || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %h rdy %b exp %h rdy 1", obs, in_ready, exp_v);
    end
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    exp_v = {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd2};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_second got %h exp %h", obs, exp_v); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 4'b0000, 32'hF0F0, 32'hFF00, 5'd4);
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy_full1 got %b exp 1", in_ready); end
    drive(1'b1, 4'b0001, 32'h1, 32'h2, 5'd5);
    step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy_full2 got %b exp 0", in_ready); end
    drive(1'b1, 4'b0010, 32'h1, 32'h1, 5'd6);
    step();
    exp_v = {1'b1, 32'hF000, 1'b0, 1'b0, 5'd4};
    checks++;
    if (obs !== exp_v || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall got %h rdy %b exp %h rdy 0", obs, in_ready, exp_v);
    end
    out_ready = 1'b1;
    step();
    exp_v = {1'b1, 32'h3, 1'b0, 1'b0, 5'd5};
    checks++;
    if (obs !== exp_v || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got %h rdy %b exp %h rdy 1", obs, in_ready, exp_v);
    end
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    exp_v = {1'b1, 32'h2, 1'b0, 1'b0, 5'd6};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bp_third got %h exp %h", obs, exp_v); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 4'b1111, 32'd3, 32'd4, 5'd9);
    step();
    drive(1'b1, 4'b0011, 32'd8, 32'd8, 5'd10);
    exp_v = {1'b1, 32'h0, 1'b1, 1'b1, 5'd9};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL illegal_f got %h exp %h", obs, exp_v); end
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    exp_v = {1'b1, 32'h0, 1'b1, 1'b1, 5'd10};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL illegal_3 got %h exp %h", obs, exp_v); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 32'd10, 32'd1, 5'd11);
    step();
    drive(1'b1, 4'b0010, 32'd20, 32'd2, 5'd12);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_setup rdy %b vld %b exp rdy 0 vld 1", in_ready, out_valid);
    end
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 4'b0010, 32'd30, 32'd3, 5'd13);
    step();
    flush = 1'b0;
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_next vld %b rdy %b exp vld 0 rdy 1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet%0d got %b exp 0", i, out_valid); end
    end
    drive(1'b1, 4'b0010, 32'd2, 32'd2, 5'd14);
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    exp_v = {1'b1, 32'd4, 1'b0, 1'b0, 5'd14};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL flush_after got %h exp %h", obs, exp_v); end
    step();
  endtask

  task automatic test_overflow_and_reset();
    drive(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd15);
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    exp_v = {1'b1, 32'h0, 1'b1, 1'b0, 5'd15};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL add_wrap got %h exp %h", obs, exp_v); end
    step();
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'h100, 32'h1, 5'd16);
    step();
    drive(1'b1, 4'b0001, 32'h200, 32'h2, 5'd17);
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_setup rdy %b vld %b exp rdy 0 vld 1", in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = 40'h0;
    checks++;
    if (obs !== exp_v || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async got %h rdy %b exp %h rdy 1", obs, in_ready, exp_v);
    end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL rst_quiet%0d vld %b rdy %b exp vld 0 rdy 1", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_overflow_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
